// File: rtl/qam_pkg.sv
// Shared defaults, output-buffer state encoding and Gray decoding for the QAM symbol mapper.
package qam_pkg;

    localparam int QAM_BITS_PER_SYM = 4;
    localparam int QAM_OUT_W        = 8;
    localparam int QAM_AMP          = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Binary bit i is the XOR of all Gray bits at or above i; zero-extended inputs decode unchanged.
    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/qam_gray_level.sv
// Combinational H-bit Gray code to signed constellation level: (2k-(M-1))*AMP.
module qam_gray_level
    import qam_pkg::*;
#(
    parameter int H     = 2,
    parameter int OUT_W = QAM_OUT_W,
    parameter int AMP   = QAM_AMP
) (
    input  logic [H-1:0]     gray_i,
    output logic [OUT_W-1:0] level_o
);

    localparam int M = 1 << H;

    logic [7:0] bin;
    int         lvl;

    always_comb begin
        bin     = gray2bin(8'(gray_i));
        lvl     = (2 * int'(bin) - (M - 1)) * AMP;
        level_o = OUT_W'(lvl);
    end

endmodule

// File: rtl/qam_symbol_mapper.sv
// Serial bit collector, Gray square-QAM mapper and 2-entry valid/ready symbol buffer.
module qam_symbol_mapper
    import qam_pkg::*;
#(
    parameter int BITS_PER_SYM = QAM_BITS_PER_SYM,
    parameter int OUT_W        = QAM_OUT_W,
    parameter int AMP          = QAM_AMP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [OUT_W-1:0] sym_i,
    output logic [OUT_W-1:0] sym_q,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [15:0]      sym_cnt,
    output logic             overflow
);

    localparam int H  = BITS_PER_SYM / 2;
    localparam int CW = (BITS_PER_SYM > 2) ? $clog2(BITS_PER_SYM) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS_PER_SYM - 1);

    buf_state_e              state_q, state_d;
    logic [BITS_PER_SYM-1:0] shift_q, shift_d;
    logic [CW-1:0]           bcnt_q, bcnt_d;
    logic [OUT_W-1:0]        head_i_q, head_i_d, head_q_q, head_q_d;
    logic [OUT_W-1:0]        skid_i_q, skid_i_d, skid_q_q, skid_q_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic                    accept, pop, complete;
    logic [BITS_PER_SYM-1:0] group;
    logic [OUT_W-1:0]        new_i, new_q;

    assign bit_ready = (state_q != FULL);
    assign sym_valid = (state_q != EMPTY);
    assign sym_i     = head_i_q;
    assign sym_q     = head_q_q;
    assign sym_cnt   = cnt_q;
    assign overflow  = ovf_q;

    assign accept   = bit_valid & bit_ready;
    assign pop      = sym_valid & sym_ready;
    assign complete = accept && (bcnt_q == LAST);
    // The incoming bit closes the group, so map from the shifted value rather than shift_q.
    assign group    = {shift_q[BITS_PER_SYM-2:0], bit_in};

    qam_gray_level #(.H(H), .OUT_W(OUT_W), .AMP(AMP)) u_level_i (
        .gray_i  (group[BITS_PER_SYM-1:H]),
        .level_o (new_i)
    );

    qam_gray_level #(.H(H), .OUT_W(OUT_W), .AMP(AMP)) u_level_q (
        .gray_i  (group[H-1:0]),
        .level_o (new_q)
    );

    always_comb begin
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        state_d  = state_q;
        head_i_d = head_i_q;
        head_q_d = head_q_q;
        skid_i_d = skid_i_q;
        skid_q_d = skid_q_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (bit_valid & ~bit_ready);

        if (accept) begin
            shift_d = group;
            bcnt_d  = complete ? '0 : bcnt_q + 1'b1;
        end

        if (pop) begin
            cnt_d = cnt_q + 16'd1;
        end

        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    head_i_d = new_i;
                    head_q_d = new_q;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (complete && pop) begin
                    head_i_d = new_i;
                    head_q_d = new_q;
                end else if (complete) begin
                    skid_i_d = new_i;
                    skid_q_d = new_q;
                    state_d  = FULL;
                end else if (pop) begin
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                // bit_ready is low here, so no group can complete in the same cycle.
                if (pop) begin
                    head_i_d = skid_i_q;
                    head_q_d = skid_q_q;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            shift_q  <= '0;
            bcnt_q   <= '0;
            head_i_q <= '0;
            head_q_q <= '0;
            skid_i_q <= '0;
            skid_q_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            head_i_q <= head_i_d;
            head_q_q <= head_q_d;
            skid_i_q <= skid_i_d;
            skid_q_q <= skid_q_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper: queue-based symbol model compared every cycle plus literal checks.
module tb_qam_symbol_mapper;

    localparam int BPS   = 4;
    localparam int OUT_W = 8;
    localparam int AMP   = 32;
    localparam int H     = BPS / 2;
    localparam int M     = 1 << H;

    logic             clock;
    logic             reset;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [OUT_W-1:0] sym_i;
    logic [OUT_W-1:0] sym_q;
    logic             sym_valid;
    logic             sym_ready;
    logic [15:0]      sym_cnt;
    logic             overflow;

    qam_symbol_mapper #(.BITS_PER_SYM(BPS), .OUT_W(OUT_W), .AMP(AMP)) dut (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_cnt   (sym_cnt),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: symbols are a queue of expected (I,Q); the buffer holds at most two of them.
    int qi[$];
    int qq[$];
    int mbits, mgrp, mcnt, last_i, last_q;
    bit movf;

    function automatic int lvl_of(input int g);
        for (int k = 0; k < M; k++) begin
            if ((k ^ (k >> 1)) == g) return (2 * k - (M - 1)) * AMP;
        end
        return 9999;
    endfunction

    task automatic model_step();
        bit rdy, vld, cmp;
        int ni, nq;
        if (!reset) begin
            qi.delete(); qq.delete();
            mbits = 0; mgrp = 0; mcnt = 0; movf = 1'b0; last_i = 0; last_q = 0;
            return;
        end
        rdy = (qi.size() < 2);
        vld = (qi.size() > 0);
        cmp = 1'b0;
        ni = 0; nq = 0;
        if (bit_valid && !rdy) movf = 1'b1;
        if (bit_valid && rdy) begin
            mgrp = (mgrp << 1) | int'(bit_in);
            mbits++;
            if (mbits == BPS) begin
                cmp = 1'b1;
                ni = lvl_of(mgrp >> H);
                nq = lvl_of(mgrp & (M - 1));
                mgrp = 0; mbits = 0;
            end
        end
        if (vld && sym_ready) begin
            last_i = qi.pop_front();
            last_q = qq.pop_front();
            mcnt = (mcnt + 1) % 65536;
        end
        if (cmp) begin
            qi.push_back(ni);
            qq.push_back(nq);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("sym_valid", int'(sym_valid), int'(qi.size() > 0));
            chk("bit_ready", int'(bit_ready), int'(qi.size() < 2));
            chk("sym_cnt", int'(sym_cnt), mcnt);
            chk("overflow", int'(overflow), int'(movf));
            if (qi.size() > 0) begin
                chk("sym_i", $signed(sym_i), qi[0]);
                chk("sym_q", $signed(sym_q), qq[0]);
            end else begin
                chk("sym_i_hold", $signed(sym_i), last_i);
                chk("sym_q_hold", $signed(sym_q), last_q);
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clock);
        bit_valid = 1'b1;
        bit_in    = b;
    endtask

    task automatic send_group(input logic [3:0] g);
        for (int b = 3; b >= 0; b--) send_bit(g[b]);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            bit_valid = 1'b0;
        end
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic assert_reset();
        @(negedge clock);
        #2;
        reset     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
    endtask

    int c0;

    initial begin
        reset     = 1'b0;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        sym_ready = 1'b0;

        // Reset held with bit_valid asserted
        repeat (3) @(negedge clock);
        #1;
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_bit_ready", int'(bit_ready), 1);
        chk("rst_sym_cnt", int'(sym_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);
        bit_valid = 1'b0;
        release_reset();
        idle(3);

        // First symbol 1,0,0,1 -> I=+96, Q=-32, one cycle after the last bit
        sym_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        after_edge();
        chk("no_sym_before_4th", int'(sym_valid), 0);
        send_bit(1'b1);
        after_edge();
        chk("map1001_valid", int'(sym_valid), 1);
        chk("map1001_i", $signed(sym_i), 96);
        chk("map1001_q", $signed(sym_q), -32);
        idle(2);

        // All 16 groups
        for (int g = 0; g < 16; g++) send_group(4'(g));
        idle(3);

        // Backpressure: two buffered symbols, 0011 then 1100
        sym_ready = 1'b0;
        send_group(4'b0011);
        send_group(4'b1100);
        after_edge();
        chk("full_bit_ready", int'(bit_ready), 0);
        chk("full_head_i", $signed(sym_i), -96);
        chk("full_head_q", $signed(sym_q), 32);

        // Overflow while FULL
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        after_edge();
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_head_i", $signed(sym_i), -96);
        chk("ovf_head_q", $signed(sym_q), 32);
        @(negedge clock);
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        after_edge();
        chk("drain1_i", $signed(sym_i), 32);
        chk("drain1_q", $signed(sym_q), -96);
        chk("drain1_bit_ready", int'(bit_ready), 1);
        idle(2);
        send_group(4'b1001);
        after_edge();
        chk("post_ovf_i", $signed(sym_i), 96);
        chk("post_ovf_q", $signed(sym_q), -32);
        chk("ovf_sticky", int'(overflow), 1);
        idle(3);

        // Simultaneous push and pop in ONE
        sym_ready = 1'b0;
        send_group(4'b0000);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        c0 = mcnt;
        send_bit(1'b1);
        sym_ready = 1'b1;
        after_edge();
        chk("pushpop_valid", int'(sym_valid), 1);
        chk("pushpop_i", $signed(sym_i), 96);
        chk("pushpop_q", $signed(sym_q), -32);
        chk("pushpop_cnt", int'(sym_cnt), (c0 + 1) % 65536);
        chk("pushpop_bit_ready", int'(bit_ready), 1);
        idle(3);

        // Reset mid-group after two bits
        send_bit(1'b0); send_bit(1'b1);
        assert_reset();
        #1;
        chk("midrst_valid", int'(sym_valid), 0);
        chk("midrst_ovf", int'(overflow), 0);
        idle(1);
        release_reset();
        send_group(4'b1001);
        after_edge();
        chk("fresh_i", $signed(sym_i), 96);
        chk("fresh_q", $signed(sym_q), -32);
        chk("fresh_cnt", int'(sym_cnt), 0);
        idle(3);

        // Reset while FULL
        sym_ready = 1'b0;
        send_group(4'b0110);
        send_group(4'b1111);
        after_edge();
        chk("full2_bit_ready", int'(bit_ready), 0);
        assert_reset();
        #1;
        chk("fullrst_valid", int'(sym_valid), 0);
        chk("fullrst_bit_ready", int'(bit_ready), 1);
        chk("fullrst_cnt", int'(sym_cnt), 0);
        chk("fullrst_i", $signed(sym_i), 0);
        release_reset();
        sym_ready = 1'b1;
        send_group(4'b1010);
        after_edge();
        chk("after_full_rst_i", $signed(sym_i), 96);
        chk("after_full_rst_q", $signed(sym_q), 96);
        idle(4);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
